// File: rtl/game_link_pkg.sv
// game_link_pkg: constants shared by the host-link byte interpreter and the
// move transmitter.
//   - protocol characters exchanged with the host
//   - state encoding of the move transmitter FSM
// Optional build macro: MOVE_TX_NEWLINE_EN adds the newline states.
package game_link_pkg;

   localparam logic [7:0] CH_W  = 8'h77;
   localparam logic [7:0] CH_L  = 8'h6C;
   localparam logic [7:0] CH_C  = 8'h63;
   localparam logic [7:0] CH_R  = 8'h72;
   localparam logic [7:0] CH_B  = 8'h62;
   localparam logic [7:0] CH_OC = 8'h7B;   // '{' opens a frame
   localparam logic [7:0] CH_CC = 8'h7D;   // '}' closes a frame
   localparam logic [7:0] CH_EN = 8'h0A;   // newline terminator

   localparam logic [3:0] ST_IDLE    = 4'd0;
   localparam logic [3:0] ST_SEND_OC = 4'd1;
   localparam logic [3:0] ST_WAIT_OC = 4'd2;
   localparam logic [3:0] ST_STREAM  = 4'd3;
   localparam logic [3:0] ST_WAIT_MV = 4'd4;
   localparam logic [3:0] ST_SEND_CC = 4'd5;
   localparam logic [3:0] ST_WAIT_CC = 4'd6;
   localparam logic [3:0] ST_SEND_NL = 4'd7;
   localparam logic [3:0] ST_WAIT_NL = 4'd8;
   localparam logic [3:0] ST_DONE    = 4'd9;

   typedef enum logic [3:0] {
      S_IDLE    = ST_IDLE,
      S_SEND_OC = ST_SEND_OC,
      S_WAIT_OC = ST_WAIT_OC,
      S_STREAM  = ST_STREAM,
      S_WAIT_MV = ST_WAIT_MV,
      S_SEND_CC = ST_SEND_CC,
      S_WAIT_CC = ST_WAIT_CC,
`ifdef MOVE_TX_NEWLINE_EN
      S_SEND_NL = ST_SEND_NL,
      S_WAIT_NL = ST_WAIT_NL,
`endif
      S_DONE    = ST_DONE
   } tx_state_e;

endpackage

// File: rtl/move_transmitter_if.sv
// move_transmitter_if: move stream from the game logic plus the UART TX
// load/busy handshake.
//   slave  : view of the move transmitter (consumes moves, drives the UART)
//   master : view of the environment (move producer + UART TX core)
interface move_transmitter_if;
   logic       move_valid;
   logic [7:0] move_data;
   logic       move_ready;
   logic       TxD_start;
   logic [7:0] TxD_data;
   logic       TxD_busy;

   modport slave  (input  move_valid, move_data, TxD_busy,
                   output move_ready, TxD_start, TxD_data);
   modport master (output move_valid, move_data, TxD_busy,
                   input  move_ready, TxD_start, TxD_data);
endinterface

// File: rtl/move_transmitter_fifo.sv
// move_fifo: single-clock byte FIFO between the move producer and the framer.
//   clk, rst (async, active-low), push/push_data, pop/pop_data (head, valid
//   whenever !empty), full, empty.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module move_fifo #(
   parameter int FIFO_DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] pop_data,
   output logic       full,
   output logic       empty
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [7:0]     mem [FIFO_DEPTH];
   logic [PTR_W:0] wr_ptr, rd_ptr;

   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign pop_data = mem[rd_ptr[PTR_W-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: only slots between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[PTR_W-1:0]] <= push_data;
   end
endmodule

// File: rtl/move_transmitter.sv
// move_transmitter: frames the local player's moves as '{' moves '}' and
// feeds them byte by byte to the UART TX core.
//   clk, rst (async, active-low)
//   me_game_start : pulse, our turn begins
//   turn_end      : pulse, last move of the turn has been offered
//   bus (slave)   : move_valid/move_data/move_ready, TxD_start/TxD_data/TxD_busy
//   frame_active  : high from turn start until the frame is complete
//   frame_done    : pulse once the final byte has left the UART
// Optional build macro: MOVE_TX_NEWLINE_EN appends 0x0A after '}'.
module move_transmitter
   import game_link_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               me_game_start,
   input  logic               turn_end,
   move_transmitter_if.slave  bus,
   output logic               frame_active,
   output logic               frame_done
);
   tx_state_e  state;
   logic       hold;       // first cycle of a WAIT_* state: UART busy not yet visible
   logic       end_seen;
   logic       fifo_full, fifo_empty, fifo_push, fifo_pop;
   logic [7:0] fifo_head;

   // Moves are accepted from turn start (even while '{' is going out) until
   // turn_end is seen.
   assign bus.move_ready = frame_active & ~fifo_full & ~end_seen;
   assign fifo_push      = bus.move_valid & bus.move_ready;
   assign fifo_pop       = (state == S_STREAM) & ~fifo_empty & ~bus.TxD_busy;

   move_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (bus.move_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_IDLE;
         hold          <= 1'b0;
         end_seen      <= 1'b0;
         frame_active  <= 1'b0;
         frame_done    <= 1'b0;
         bus.TxD_start <= 1'b0;
         bus.TxD_data  <= 8'h00;
      end else begin
         bus.TxD_start <= 1'b0;
         frame_done    <= 1'b0;
         if (frame_active && turn_end) end_seen <= 1'b1;

         case (state)
            S_IDLE: begin
               if (me_game_start) begin
                  frame_active <= 1'b1;
                  state        <= S_SEND_OC;
               end
            end
            S_SEND_OC: begin
               if (!bus.TxD_busy) begin
                  bus.TxD_data  <= CH_OC;
                  bus.TxD_start <= 1'b1;
                  hold          <= 1'b1;
                  state         <= S_WAIT_OC;
               end
            end
            S_WAIT_OC: begin
               if (hold)                hold  <= 1'b0;
               else if (!bus.TxD_busy)  state <= S_STREAM;
            end
            S_STREAM: begin
               if (fifo_pop) begin
                  bus.TxD_data  <= fifo_head;
                  bus.TxD_start <= 1'b1;
                  hold          <= 1'b1;
                  state         <= S_WAIT_MV;
               end else if (fifo_empty && end_seen) begin
                  state <= S_SEND_CC;
               end
            end
            S_WAIT_MV: begin
               if (hold)                hold  <= 1'b0;
               else if (!bus.TxD_busy)  state <= S_STREAM;
            end
            S_SEND_CC: begin
               if (!bus.TxD_busy) begin
                  bus.TxD_data  <= CH_CC;
                  bus.TxD_start <= 1'b1;
                  hold          <= 1'b1;
                  state         <= S_WAIT_CC;
               end
            end
            S_WAIT_CC: begin
               if (hold) hold <= 1'b0;
               else if (!bus.TxD_busy) begin
`ifdef MOVE_TX_NEWLINE_EN
                  state <= S_SEND_NL;
`else
                  state <= S_DONE;
`endif
               end
            end
`ifdef MOVE_TX_NEWLINE_EN
            S_SEND_NL: begin
               if (!bus.TxD_busy) begin
                  bus.TxD_data  <= CH_EN;
                  bus.TxD_start <= 1'b1;
                  hold          <= 1'b1;
                  state         <= S_WAIT_NL;
               end
            end
            S_WAIT_NL: begin
               if (hold)                hold  <= 1'b0;
               else if (!bus.TxD_busy)  state <= S_DONE;
            end
`endif
            S_DONE: begin
               frame_done   <= 1'b1;
               frame_active <= 1'b0;
               end_seen     <= 1'b0;   // overrides a turn_end landing here
               state        <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_move_transmitter.sv
module tb_move_transmitter;
   import game_link_pkg::*;

   localparam int DEPTH = 4;
   typedef logic [7:0] bq_t[$];

   typedef struct {
      string            name;
      int               nmov;
      logic [0:9][7:0]  mv;
      int               busy;
      int               gap;
      bit               same;
      bit               restart;
      int               nexp;
      logic [0:11][7:0] ex;
   } vec_t;

   logic clk = 1'b0, rst = 1'b0, me_game_start = 1'b0, turn_end = 1'b0;
   logic frame_active, frame_done;

   move_transmitter_if bus();

   move_transmitter #(.FIFO_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst           (rst),
      .me_game_start (me_game_start),
      .turn_end      (turn_end),
      .bus           (bus.slave),
      .frame_active  (frame_active),
      .frame_done    (frame_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_bad = 0;
   int busy_len = 10, busy_cnt = 0, done_cnt = 0, acc_n = 0;
   logic [7:0] tx_log[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // UART TX model: busy rises the cycle after a sampled start, lasts busy_len cycles.
   assign bus.TxD_busy = (busy_cnt != 0);
   always @(posedge clk or negedge rst) begin
      if (!rst) busy_cnt <= 0;
      else if (bus.TxD_start === 1'b1) begin
         chk("start_while_busy", {31'd0, bus.TxD_busy}, 0);
         tx_log.push_back(bus.TxD_data);
         busy_cnt <= busy_len;
      end else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
   end

   always @(negedge clk) if (frame_done === 1'b1) done_cnt++;

   // Offer one byte and hold it until taken; optionally raise turn_end in the
   // accepting cycle.
   task automatic offer(input logic [7:0] b, input bit end_here);
      int t = 0;
      @(negedge clk);
      turn_end = 1'b0; bus.move_valid = 1'b1; bus.move_data = b;
      while (bus.move_ready !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
      chk("offer_accepted", {31'd0, bus.move_ready}, 1);
      turn_end = end_here;
      acc_n++;
   endtask

   task automatic run_turn(input bq_t mv, input int busy, input int gap, input bit same,
                           input bit restart, input bq_t exp, input string name);
      int t = 0;
      busy_len = busy; tx_log.delete(); done_cnt = 0; acc_n = 0;
`ifdef MOVE_TX_NEWLINE_EN
      exp.push_back(CH_EN);
`endif
      @(negedge clk); me_game_start = 1'b1;
      @(negedge clk); me_game_start = 1'b0;
      @(negedge clk);
      chk({name, "_latency"}, {23'd0, bus.TxD_start, bus.TxD_data}, {23'd0, 1'b1, CH_OC});
      foreach (mv[i]) offer(mv[i], same && (i == mv.size() - 1));
      @(negedge clk); bus.move_valid = 1'b0; turn_end = 1'b0;
      if (restart) begin
         me_game_start = 1'b1; @(negedge clk); me_game_start = 1'b0;
      end
      if (!(same && mv.size() > 0)) begin
         repeat (gap) @(negedge clk);
         turn_end = 1'b1; @(negedge clk); turn_end = 1'b0;
      end
      while (done_cnt == 0 && t < 5000) begin @(negedge clk); t++; end
      repeat (3) @(negedge clk);
      chk({name, "_done_pulses"}, done_cnt, 1);
      chk({name, "_active_low"}, {31'd0, frame_active}, 0);
      chk({name, "_len"}, tx_log.size(), exp.size());
      foreach (exp[i])
         chk($sformatf("%s_byte%0d", name, i), (i < tx_log.size()) ? {24'd0, tx_log[i]} : 32'hFFFF_FFFF, {24'd0, exp[i]});
   endtask

   vec_t vt[5];

   initial begin
      bq_t mq, eq;
      int t;
      vt[0] = '{"empty",   0, 80'h0,                             10, 3, 0, 0, 2, {CH_OC, CH_CC, 80'h0}};
      vt[1] = '{"three",   3, {8'h01, 8'h05, 8'h07, 56'h0},      10, 1, 0, 0, 5, {CH_OC, 8'h01, 8'h05, 8'h07, CH_CC, 56'h0}};
      vt[2] = '{"same",    2, {8'h21, 8'h22, 64'h0},              3, 0, 1, 0, 4, {CH_OC, 8'h21, 8'h22, CH_CC, 64'h0}};
      vt[3] = '{"restart", 1, {8'h09, 72'h0},                     4, 2, 0, 1, 3, {CH_OC, 8'h09, CH_CC, 72'h0}};
      vt[4] = '{"one",     1, {8'h03, 72'h0},                    10, 1, 0, 0, 3, {CH_OC, 8'h03, CH_CC, 72'h0}};

      bus.move_valid = 1'b0; bus.move_data = 8'h00;

      // Reset state
      #12;
      chk("rst_txd_start", {31'd0, bus.TxD_start}, 0);
      chk("rst_txd_data", {24'd0, bus.TxD_data}, 0);
      chk("rst_move_ready", {31'd0, bus.move_ready}, 0);
      chk("rst_frame_active", {31'd0, frame_active}, 0);
      chk("rst_frame_done", {31'd0, frame_done}, 0);
      @(negedge clk); rst = 1'b1;

      // move_valid in IDLE is never accepted
      @(negedge clk); bus.move_valid = 1'b1; bus.move_data = 8'h55;
      repeat (4) begin @(negedge clk); chk("idle_ready", {31'd0, bus.move_ready}, 0); end
      bus.move_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_no_tx", tx_log.size(), 0);

      // Table vectors
      foreach (vt[k]) begin
         mq.delete(); eq.delete();
         for (int i = 0; i < vt[k].nmov; i++) mq.push_back(vt[k].mv[i]);
         for (int i = 0; i < vt[k].nexp; i++) eq.push_back(vt[k].ex[i]);
         run_turn(mq, vt[k].busy, vt[k].gap, vt[k].same, vt[k].restart, eq, vt[k].name);
      end

      // Backpressure: only DEPTH moves fit while '{' is still on the wire
      mq.delete(); eq.delete(); eq.push_back(CH_OC);
      for (int i = 0; i < 10; i++) begin mq.push_back(8'h40 + 8'(i)); eq.push_back(8'h40 + 8'(i)); end
      eq.push_back(CH_CC);
      fork
         run_turn(mq, 50, 2, 0, 0, eq, "bp");
         begin
            repeat (16) @(negedge clk);
            chk("bp_buffered", acc_n, DEPTH);
            chk("bp_ready_low", {31'd0, bus.move_ready}, 0);
         end
      join

      // Reset while waiting on a move byte
      busy_len = 10; tx_log.delete();
      @(negedge clk); me_game_start = 1'b1;
      @(negedge clk); me_game_start = 1'b0;
      offer(8'h11, 0); offer(8'h12, 0); offer(8'h13, 0);
      @(negedge clk); bus.move_valid = 1'b0;
      t = 0;
      while (tx_log.size() < 2 && t < 2000) begin @(negedge clk); t++; end
      chk("rst_mid_reached", tx_log.size(), 2);
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_txd_start", {31'd0, bus.TxD_start}, 0);
      chk("mid_rst_txd_data", {24'd0, bus.TxD_data}, 0);
      chk("mid_rst_move_ready", {31'd0, bus.move_ready}, 0);
      chk("mid_rst_frame_active", {31'd0, frame_active}, 0);
      chk("mid_rst_frame_done", {31'd0, frame_done}, 0);
      @(negedge clk); rst = 1'b1;
      mq.delete(); mq.push_back(8'h21);
      eq.delete(); eq.push_back(CH_OC); eq.push_back(8'h21); eq.push_back(CH_CC);
      run_turn(mq, 4, 2, 0, 0, eq, "post_rst");

      // Randomized turns against the frame model: '{' + moves in order + '}'
      for (int r = 0; r < 20; r++) begin
         int n;
         logic [7:0] b;
         n = $urandom_range(0, 10);
         mq.delete(); eq.delete(); eq.push_back(CH_OC);
         for (int i = 0; i < n; i++) begin
            do b = 8'($urandom_range(0, 255)); while (b == CH_OC || b == CH_CC);
            mq.push_back(b); eq.push_back(b);
         end
         eq.push_back(CH_CC);
         run_turn(mq, $urandom_range(1, 12), $urandom_range(0, 5),
                  (n > 0) && ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0),
                  eq, $sformatf("rnd%0d", r));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
